// File: rtl/eco32f_pkg.sv
// Shared eco32f definitions: LSU size codes, memory-stage state encoding,
// the memory-stage pipeline register bundle and an alignment helper.
package eco32f_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ABORT  = 2'd3
    } mem_state_e;

    // Everything captured from execute and held while the stage works.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [1:0]  lsu_len;
        logic        lsu_sext;
        logic        op_load;
        logic        op_store;
        logic        rf_r_we;
        logic [4:0]  rf_r_addr;
        logic        except_align;
    } mem_regs_t;

    // Half accesses need an even address, words (and the unused code 3)
    // a word-aligned one; bytes are always aligned.
    function automatic logic lsu_misaligned(input logic [1:0] len, input logic [1:0] off);
        case (len)
            LSU_BYTE: return 1'b0;
            LSU_HALF: return off[0];
            default:  return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/eco32f_mem_if.sv
// Data bus between the memory stage (master) and the memory system (slave).
interface eco32f_mem_if;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;

    modport master (output req, we, adr, sel, dat_o, input dat_i, ack);
    modport slave  (input req, we, adr, sel, dat_o, output dat_i, ack);
endinterface

// File: rtl/eco32f_lsu_align.sv
// Combinational big-endian lane steering: misalignment check on the incoming
// access, byte enables and store replication for the registered access, and
// extraction/extension of the returned load data.
module eco32f_lsu_align
    import eco32f_pkg::*;
(
    input  logic [1:0]  chk_addr_lo,
    input  logic [1:0]  chk_len,
    output logic        chk_misaligned,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  len,
    input  logic        sext,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  sel,
    output logic [31:0] store_lanes,
    output logic [31:0] load_result
);
    logic [31:0] load_shifted;

    assign chk_misaligned = lsu_misaligned(chk_len, chk_addr_lo);

    // Move the addressed lane to the top of the word so extraction is uniform.
    assign load_shifted = load_data << {addr_lo, 3'b000};

    // Byte enables, store replication and load extension per access size.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        sel         = 4'b1111;
        store_lanes = store_data;
        load_result = load_data;
        case (len)
            LSU_BYTE: begin
                sel         = 4'b1000 >> addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_result = {{24{sext & load_shifted[31]}}, load_shifted[31:24]};
            end
            LSU_HALF: begin
                sel         = addr_lo[1] ? 4'b0011 : 4'b1100;
                store_lanes = {2{store_data[15:0]}};
                load_result = {{16{sext & load_shifted[31]}}, load_shifted[31:16]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/eco32f_mem.sv
// eco32f memory stage: registers execute results, runs one outstanding
// load/store on the data bus and flags misaligned accesses.
module eco32f_mem
    import eco32f_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                do_exception,
    input  logic [31:0]         exe_pc,
    input  logic [31:0]         exe_alu_result,
    input  logic [31:0]         exe_store_data,
    input  logic                exe_op_load,
    input  logic                exe_op_store,
    input  logic [1:0]          exe_lsu_len,
    input  logic                exe_lsu_sext,
    input  logic                exe_rf_r_we,
    input  logic [4:0]          exe_rf_r_addr,
    eco32f_mem_if.master        dbus,
    output logic                mem_stall,
    output logic [31:0]         mem_pc,
    output logic [31:0]         mem_alu_result,
    output logic [31:0]         mem_lsu_result,
    output logic                mem_rf_r_we,
    output logic                mem_op_load,
    output logic                mem_except_align,
    output logic [4:0]          mem_rf_r_addr
);
    mem_state_e  state_q, state_d;
    mem_regs_t   regs_q, regs_d;
    logic [31:0] lsu_result_q, lsu_result_d;
    logic        dbus_req_q, dbus_req_d;
    logic        mem_stall_q, mem_stall_d;

    logic        capture;
    logic        exe_mem_op;
    logic        exe_misaligned;
    logic [3:0]  lane_sel;
    logic [31:0] lane_store;
    logic [31:0] lane_load;

    eco32f_lsu_align u_align (
        .chk_addr_lo    (exe_alu_result[1:0]),
        .chk_len        (exe_lsu_len),
        .chk_misaligned (exe_misaligned),
        .addr_lo        (regs_q.alu_result[1:0]),
        .len            (regs_q.lsu_len),
        .sext           (regs_q.lsu_sext),
        .store_data     (regs_q.store_data),
        .load_data      (dbus.dat_i),
        .sel            (lane_sel),
        .store_lanes    (lane_store),
        .load_result    (lane_load)
    );

    assign capture    = !mem_stall_q && !do_exception;
    assign exe_mem_op = exe_op_load | exe_op_store;

    // Next-state, capture and flush decisions for the stage.
    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        lsu_result_d = lsu_result_q;
        dbus_req_d   = dbus_req_q;
        mem_stall_d  = mem_stall_q;

        if (capture) begin
            regs_d.pc           = exe_pc;
            regs_d.alu_result   = exe_alu_result;
            regs_d.store_data   = exe_store_data;
            regs_d.lsu_len      = exe_lsu_len;
            regs_d.lsu_sext     = exe_lsu_sext;
            regs_d.op_load      = exe_op_load;
            regs_d.op_store     = exe_op_store;
            regs_d.rf_r_addr    = exe_rf_r_addr;
            regs_d.except_align = exe_mem_op & exe_misaligned;
            regs_d.rf_r_we      = exe_rf_r_we & !(exe_mem_op & exe_misaligned);
            if (exe_mem_op && !exe_misaligned) begin
                state_d     = ST_ACCESS;
                dbus_req_d  = 1'b1;
                mem_stall_d = 1'b1;
            end else begin
                state_d     = ST_IDLE;
                dbus_req_d  = 1'b0;
                mem_stall_d = 1'b0;
            end
        end else begin
            if (do_exception) begin
                regs_d.rf_r_we      = 1'b0;
                regs_d.op_load      = 1'b0;
                regs_d.except_align = 1'b0;
            end
            case (state_q)
                ST_ACCESS: begin
                    if (dbus.ack) begin
                        state_d     = do_exception ? ST_IDLE : ST_DONE;
                        dbus_req_d  = 1'b0;
                        mem_stall_d = 1'b0;
                        if (!do_exception) lsu_result_d = lane_load;
                    end else if (do_exception) begin
                        state_d = ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    // The bus cycle in flight completes; its data is dropped.
                    if (dbus.ack) begin
                        state_d     = ST_IDLE;
                        dbus_req_d  = 1'b0;
                        mem_stall_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    dbus_req_d  = 1'b0;
                    mem_stall_d = 1'b0;
                end
            endcase
        end
    end

    // State, handshake and pipeline registers; reset also drops dbus_req at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            regs_q       <= '0;
            lsu_result_q <= '0;
            dbus_req_q   <= 1'b0;
            mem_stall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q      <= state_d;
            regs_q       <= regs_d;
            lsu_result_q <= lsu_result_d;
            dbus_req_q   <= dbus_req_d;
            mem_stall_q  <= mem_stall_d;
        end
    end

    // Bus fields come from held registers, so they stay stable for the whole
    // request; outside a request they read as zero.
    assign dbus.req   = dbus_req_q;
    assign dbus.we    = dbus_req_q & regs_q.op_store;
    assign dbus.adr   = dbus_req_q ? {regs_q.alu_result[31:2], 2'b00} : 32'h0;
    assign dbus.sel   = dbus_req_q ? lane_sel : 4'h0;
    assign dbus.dat_o = dbus_req_q ? lane_store : 32'h0;

    assign mem_stall        = mem_stall_q;
    assign mem_pc           = regs_q.pc;
    assign mem_alu_result   = regs_q.alu_result;
    assign mem_lsu_result   = lsu_result_q;
    assign mem_rf_r_we      = regs_q.rf_r_we;
    assign mem_op_load      = regs_q.op_load;
    assign mem_except_align = regs_q.except_align;
    assign mem_rf_r_addr    = regs_q.rf_r_addr;

endmodule

// File: tb/tb_eco32f_mem.sv
// Directed bench for the eco32f memory stage with hand-computed expectations.
module tb_eco32f_mem;

    logic        clk;
    logic        rst;
    logic        do_exception;
    logic [31:0] exe_pc, exe_alu_result, exe_store_data;
    logic        exe_op_load, exe_op_store, exe_lsu_sext, exe_rf_r_we;
    logic [1:0]  exe_lsu_len;
    logic [4:0]  exe_rf_r_addr;
    logic        mem_stall, mem_rf_r_we, mem_op_load, mem_except_align;
    logic [31:0] mem_pc, mem_alu_result, mem_lsu_result;
    logic [4:0]  mem_rf_r_addr;

    int tests_run = 0;
    int tests_failed = 0;

    eco32f_mem_if dbus_if ();

    eco32f_mem dut (
        .clk              (clk),
        .rst              (rst),
        .do_exception     (do_exception),
        .exe_pc           (exe_pc),
        .exe_alu_result   (exe_alu_result),
        .exe_store_data   (exe_store_data),
        .exe_op_load      (exe_op_load),
        .exe_op_store     (exe_op_store),
        .exe_lsu_len      (exe_lsu_len),
        .exe_lsu_sext     (exe_lsu_sext),
        .exe_rf_r_we      (exe_rf_r_we),
        .exe_rf_r_addr    (exe_rf_r_addr),
        .dbus             (dbus_if),
        .mem_stall        (mem_stall),
        .mem_pc           (mem_pc),
        .mem_alu_result   (mem_alu_result),
        .mem_lsu_result   (mem_lsu_result),
        .mem_rf_r_we      (mem_rf_r_we),
        .mem_op_load      (mem_op_load),
        .mem_except_align (mem_except_align),
        .mem_rf_r_addr    (mem_rf_r_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        exe_pc = 32'h0; exe_alu_result = 32'h0; exe_store_data = 32'h0;
        exe_op_load = 1'b0; exe_op_store = 1'b0; exe_lsu_len = 2'd0;
        exe_lsu_sext = 1'b0; exe_rf_r_we = 1'b0; exe_rf_r_addr = 5'd0;
    endtask

    task automatic drive_op(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data,
                            input logic ld, input logic st, input logic [1:0] len,
                            input logic sx, input logic we, input logic [4:0] rd);
        exe_pc = pc; exe_alu_result = addr; exe_store_data = data;
        exe_op_load = ld; exe_op_store = st; exe_lsu_len = len;
        exe_lsu_sext = sx; exe_rf_r_we = we; exe_rf_r_addr = rd;
    endtask

    initial begin
        rst = 1'b1;
        do_exception = 1'b0;
        dbus_if.ack = 1'b0;
        dbus_if.dat_i = 32'h0;
        drive_nop();
        #1 rst = 1'b0;
        #10;

        // Reset state
        check("rst_req", dbus_if.req, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_sel", dbus_if.sel, 4'h0);
        check("rst_adr", dbus_if.adr, 32'h0);
        check("rst_we", mem_rf_r_we, 1'b0);
        check("rst_lsu", mem_lsu_result, 32'h0);
        @(negedge clk) rst = 1'b1;
        step();

        // Load byte sext at 0x1001, zero-wait
        drive_op(32'h100, 32'h1001, 32'h0, 1, 0, 2'd0, 1, 1, 5'd5);
        dbus_if.ack = 1'b1; dbus_if.dat_i = 32'h11802233;
        step();
        check("lb_req", dbus_if.req, 1'b1);
        check("lb_stall", mem_stall, 1'b1);
        check("lb_sel", dbus_if.sel, 4'b0100);
        check("lb_adr", dbus_if.adr, 32'h1000);
        check("lb_we", dbus_if.we, 1'b0);
        step();
        check("lb_done_stall", mem_stall, 1'b0);
        check("lb_done_req", dbus_if.req, 1'b0);
        check("lb_result", mem_lsu_result, 32'hFFFFFF80);
        check("lb_rf_we", mem_rf_r_we, 1'b1);
        check("lb_rd", mem_rf_r_addr, 5'd5);
        check("lb_pc", mem_pc, 32'h100);
        drive_nop(); dbus_if.ack = 1'b0;
        step();
        check("lb_idle_opload", mem_op_load, 1'b0);

        // Store half at 0x2002 with one wait state
        drive_op(32'h104, 32'h2002, 32'h0000ABCD, 0, 1, 2'd1, 0, 0, 5'd0);
        step();
        check("sh_sel", dbus_if.sel, 4'b0011);
        check("sh_dat", dbus_if.dat_o, 32'hABCDABCD);
        check("sh_we", dbus_if.we, 1'b1);
        check("sh_adr", dbus_if.adr, 32'h2000);
        step();
        check("sh_wait_req", dbus_if.req, 1'b1);
        check("sh_wait_dat", dbus_if.dat_o, 32'hABCDABCD);
        dbus_if.ack = 1'b1; drive_nop();
        step();
        check("sh_done_stall", mem_stall, 1'b0);
        dbus_if.ack = 1'b0;
        step();

        // Misaligned load word at 0x3002
        drive_op(32'h108, 32'h3002, 32'h0, 1, 0, 2'd2, 0, 1, 5'd3);
        step();
        check("mis_align", mem_except_align, 1'b1);
        check("mis_req", dbus_if.req, 1'b0);
        check("mis_rf_we", mem_rf_r_we, 1'b0);
        check("mis_stall", mem_stall, 1'b0);
        drive_nop();
        step();
        check("mis_clear", mem_except_align, 1'b0);
        check("mis_req2", dbus_if.req, 1'b0);

        // Load word with 3 wait states
        drive_op(32'h10C, 32'h4000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd7);
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw3_stall", mem_stall, 1'b1);
            step();
        end
        check("lw3_stall_last", mem_stall, 1'b1);
        dbus_if.ack = 1'b1; dbus_if.dat_i = 32'hDEADBEEF;
        step();
        check("lw3_done_stall", mem_stall, 1'b0);
        check("lw3_result", mem_lsu_result, 32'hDEADBEEF);
        check("lw3_rf_we", mem_rf_r_we, 1'b1);

        // Back-to-back: byte load at offset 3, zero-extended, captured in DONE
        drive_op(32'h110, 32'h1003, 32'h0, 1, 0, 2'd0, 0, 1, 5'd8);
        dbus_if.dat_i = 32'h123456F0;
        step();
        check("b2b_req", dbus_if.req, 1'b1);
        check("b2b_sel", dbus_if.sel, 4'b0001);
        step();
        check("b2b_result", mem_lsu_result, 32'h000000F0);
        // Half load at offset 0, sign-extended, again back-to-back
        drive_op(32'h114, 32'h5000, 32'h0, 1, 0, 2'd1, 1, 1, 5'd9);
        dbus_if.dat_i = 32'h80011234;
        step();
        check("lh_req", dbus_if.req, 1'b1);
        check("lh_sel", dbus_if.sel, 4'b1100);
        step();
        check("lh_result", mem_lsu_result, 32'hFFFF8001);
        drive_nop(); dbus_if.ack = 1'b0;
        step();

        // Exception one cycle into a 2-wait load
        drive_op(32'h118, 32'h6000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd10);
        step();
        step();
        do_exception = 1'b1;
        step();
        check("abt_req", dbus_if.req, 1'b1);
        check("abt_stall", mem_stall, 1'b1);
        check("abt_rf_we", mem_rf_r_we, 1'b0);
        check("abt_opload", mem_op_load, 1'b0);
        check("abt_adr", dbus_if.adr, 32'h6000);
        do_exception = 1'b0; drive_nop();
        dbus_if.ack = 1'b1; dbus_if.dat_i = 32'hCAFEF00D;
        step();
        check("abt_idle_req", dbus_if.req, 1'b0);
        check("abt_idle_stall", mem_stall, 1'b0);
        check("abt_result_kept", mem_lsu_result, 32'hFFFF8001);
        check("abt_idle_rf_we", mem_rf_r_we, 1'b0);
        dbus_if.ack = 1'b0;
        step();

        // Exception and ack together in ACCESS
        drive_op(32'h11C, 32'h7000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd11);
        step();
        do_exception = 1'b1; dbus_if.ack = 1'b1; dbus_if.dat_i = 32'h11111111;
        step();
        check("exack_req", dbus_if.req, 1'b0);
        check("exack_stall", mem_stall, 1'b0);
        check("exack_result", mem_lsu_result, 32'hFFFF8001);
        check("exack_rf_we", mem_rf_r_we, 1'b0);
        do_exception = 1'b0; dbus_if.ack = 1'b0; drive_nop();
        step();

        // Reset asserted mid-access, then a clean access afterwards
        drive_op(32'h800, 32'h8000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd12);
        step();
        check("rma_req_before", dbus_if.req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rma_req", dbus_if.req, 1'b0);
        check("rma_stall", mem_stall, 1'b0);
        check("rma_adr", dbus_if.adr, 32'h0);
        check("rma_pc", mem_pc, 32'h0);
        check("rma_rf_we", mem_rf_r_we, 1'b0);
        check("rma_lsu", mem_lsu_result, 32'h0);
        @(negedge clk) rst = 1'b1;
        drive_op(32'h900, 32'h9000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd13);
        dbus_if.ack = 1'b1; dbus_if.dat_i = 32'h0BADF00D;
        step();
        check("post_req", dbus_if.req, 1'b1);
        check("post_adr", dbus_if.adr, 32'h9000);
        check("post_sel", dbus_if.sel, 4'b1111);
        drive_nop();
        step();
        check("post_result", mem_lsu_result, 32'h0BADF00D);
        check("post_stall", mem_stall, 1'b0);
        dbus_if.ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eco32f_mem.md
# eco32f_mem

Memory stage of the eco32f pipeline, between execute and writeback. It registers execute results, runs single-outstanding load/store accesses on the data bus with big-endian byte-lane steering, and detects misaligned accesses. It drives the `mem_*` bundle and `mem_stall` consumed by the writeback stage.

## Interface
- Parameters: none.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-low (asserted when 0).
- `do_exception`  in  1  pipeline flush request from the exception unit.
- `exe_pc`  in  32  PC of the instruction leaving execute.
- `exe_alu_result`  in  32  ALU result; effective address for loads and stores.
- `exe_store_data`  in  32  store operand (rs2).
- `exe_op_load`, `exe_op_store`  in  1 each  access type; mutually exclusive.
- `exe_lsu_len`  in  2  access size: 0 = byte, 1 = half, 2 = word.
- `exe_lsu_sext`  in  1  sign-extend load result.
- `exe_rf_r_we`  in  1  register writeback enable.
- `exe_rf_r_addr`  in  5  destination register.
- `dbus_req`  out  1  bus request; held until ack.
- `dbus_we`  out  1  write access.
- `dbus_adr`  out  32  word-aligned address (bits [1:0] = 0).
- `dbus_sel`  out  4  byte enables; bit 3 = bits [31:24].
- `dbus_dat_o`  out  32  write data.
- `dbus_dat_i`  in  32  read data.
- `dbus_ack`  in  1  access complete.
- `mem_stall`  out  1  stage busy; upstream holds, writeback does not sample.
- `mem_pc`, `mem_alu_result`, `mem_lsu_result`  out  32 each.
- `mem_rf_r_we`, `mem_op_load`, `mem_except_align`  out  1 each.
- `mem_rf_r_addr`  out  5.

## Operation
- Capture: on each edge where `!mem_stall & !do_exception`, all `exe_*` fields load into the `mem_*` registers.
- FSM states:
  - IDLE: no access.
  - ACCESS: `dbus_req` = 1, `mem_stall` = 1.
  - DONE: result valid, `mem_stall` = 0.
  - ABORT: `dbus_req` = 1, `mem_stall` = 1, result discarded.
- Transitions:
  - A captured aligned load/store: any state → ACCESS.
  - A captured misaligned access: `mem_except_align` = 1, no bus access, state IDLE.
  - A captured non-memory instruction: → IDLE.
  - ACCESS + `dbus_ack` → DONE; the load result registers into `mem_lsu_result`.
  - DONE with no new access captured → IDLE.
- Alignment rules:
  - Half: address bit 0 must be 0.
  - Word: address bits [1:0] must be 00.
  - A misaligned access forces `mem_rf_r_we` = 0.
- Lanes (big-endian):
  - Byte at offset k: sel = 4'b1000 >> k, data in bits [31−8k : 24−8k].
  - Half at offset 0: sel 1100, bits [31:16]. Half at offset 2: sel 0011, bits [15:0].
  - Word: sel 1111.
  - Store data: byte replicated ×4, half replicated ×2.
  - Load data: extracted lane, zero- or sign-extended to 32 bits per `sext`.
- `dbus_adr`, `dbus_we`, `dbus_sel`, `dbus_dat_o` are stable for the whole request.
- `do_exception` behaviour:
  - Clears `mem_rf_r_we`, `mem_op_load`, `mem_except_align`, and blocks capture.
  - In ACCESS it goes to ABORT: the request is held until ack, then IDLE. An in-flight bus cycle is never abandoned.
  - In IDLE or DONE it goes to IDLE.

## Timing
- Reset values: every output 0, FSM IDLE.
- Reset asserted mid-access drops `dbus_req` asynchronously.
- Zero-wait load: captured at edge E0 → ACCESS in cycle 0 with `dbus_ack` → DONE in cycle 1, where writeback samples. That is one stall cycle.
- Each bus wait state adds one stall cycle.
- Non-memory instructions and misaligned accesses have 0 stall cycles.
- Back-to-back accesses: a new access captured in DONE goes directly to ACCESS, with no idle bubble on the bus.
- `dbus_ack` is ignored outside ACCESS and ABORT.
- Simultaneous `do_exception` and `dbus_ack` in ACCESS → IDLE, with the result discarded.

## Structure
- Shared `eco32f_pkg` holds:
  - LSU size codes `LSU_BYTE`, `LSU_HALF`, `LSU_WORD`.
  - Memory-stage state encodings.
- One combinational sub-module, `eco32f_lsu_align`. It covers:
  - misalignment detection;
  - `dbus_sel` and store-data steering;
  - load extraction and extension.
- The FSM and pipeline registers stay in `eco32f_mem`.

## Test plan
- Load byte, sext=1, addr 0x1001, `dbus_dat_i` 0x11_80_22_33, zero-wait → sel 0100, `mem_lsu_result` 0xFFFFFF80, exactly one stall cycle.
- Store half, addr 0x2002, data 0x0000ABCD → `dbus_sel` 0011, `dbus_dat_o` 0xABCDABCD, `dbus_we` = 1, `dbus_adr` 0x2000.
- Load word, addr 0x3002 → `mem_except_align` = 1, `dbus_req` never asserts, `mem_rf_r_we` = 0, `mem_stall` = 0.
- Load word with 3 wait states, then ack with 0xDEADBEEF → `mem_stall` high for 4 cycles, `mem_lsu_result` 0xDEADBEEF in the DONE cycle.
- `do_exception` one cycle into a 2-wait load → `dbus_req` held until ack, `mem_rf_r_we` = 0, then IDLE; no writeback of load data.
- Reset (`rst` = 0) asserted while `dbus_req` is high → all outputs 0 immediately; the next access after release starts cleanly.
